// File: rtl/scan_sequencer.sv
// Scan sequencer: walks the eight 3-to-8 decoder channels in a programmable
// direction, skipping masked channels, with a decoder-disabled blanking gap before each one.
module scan_sequencer #(
    parameter int unsigned BLANK_CYC = 2,
    parameter int unsigned DWELL_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               step,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         mask,
    output logic               A,
    output logic               B,
    output logic               C,
    output logic               G1,
    output logic               GA,
    output logic               GB,
    output logic               wrap
);

    typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;

    localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYC - 1);

    state_t             state_q, state_d;
    logic [2:0]         chan_q, chan_d;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d;
    logic [3:0]         bcnt_q, bcnt_d;
    logic               wrap_q, wrap_d;
    logic [2:0]         next_chan;
    logic               advance;

    // First enabled channel at or after start, walking in direction d modulo 8.
    function automatic logic [2:0] search(input logic [2:0] start, input logic d,
                                          input logic [7:0] m);
        logic [2:0] idx;
        logic [2:0] res;
        logic       found;
        res   = start;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = d ? start - 3'(i) : start + 3'(i);
            if (!found && m[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        dcnt_d    = dcnt_q;
        bcnt_d    = bcnt_q;
        wrap_d    = 1'b0;
        advance   = 1'b0;
        next_chan = search(dir ? chan_q - 3'd1 : chan_q + 3'd1, dir, mask);

        if (mask == '0) begin
            state_d = OFF;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = BLANK;
                    chan_d  = search(chan_q, dir, mask);
                    bcnt_d  = '0;
                end
                BLANK: begin
                    if (bcnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        dcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
                SHOW: begin
                    // A channel masked off while shown is abandoned immediately.
                    advance = !mask[chan_q] || (run && (dcnt_q >= dwell)) || (!run && step);
                    if (advance) begin
                        state_d = BLANK;
                        chan_d  = next_chan;
                        bcnt_d  = '0;
                        wrap_d  = dir ? (next_chan >= chan_q) : (next_chan <= chan_q);
                    end else if (run) begin
                        dcnt_d = dcnt_q + DWELL_W'(1);
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            chan_q  <= '0;
            dcnt_q  <= '0;
            bcnt_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            dcnt_q  <= dcnt_d;
            bcnt_q  <= bcnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign {C, B, A} = chan_q;
    assign G1        = (state_q != OFF);
    assign GA        = (state_q != SHOW);
    assign GB        = (state_q == OFF);
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: per-cycle expected {G1,GA,GB,wrap,C,B,A} vectors are
// queued as each scenario is set up, then popped and compared one per clock.
module tb_scan_sequencer;

    localparam int unsigned BC = 2;

    logic        clk = 1'b0;
    logic        rst, run, step, dir;
    logic [15:0] dwell;
    logic [7:0]  mask;
    logic        A, B, C, G1, GA, GB, wrap;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [6:0]  exp_q[$];
    logic [6:0]  e, obs;

    localparam logic [6:0] RESET_VEC = {3'b011, 1'b0, 3'b000};

    scan_sequencer #(.BLANK_CYC(BC), .DWELL_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .dir(dir),
        .dwell(dwell), .mask(mask),
        .A(A), .B(B), .C(C), .G1(G1), .GA(GA), .GB(GB), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Queue one channel visit: BC blanking cycles (wrap on the first) then nshow SHOW cycles.
    function automatic void push_chan(input int unsigned ch, input logic w, input int unsigned nshow);
        logic [2:0] c3;
        c3 = 3'(ch);
        exp_q.push_back({3'b110, w, c3});
        for (int unsigned i = 1; i < BC; i++) exp_q.push_back({3'b110, 1'b0, c3});
        for (int unsigned i = 0; i < nshow; i++) exp_q.push_back({3'b100, 1'b0, c3});
    endfunction

    task automatic test_reset();
        mask = 8'hFF; run = 1'b1; dir = 1'b0; dwell = 16'd3; step = 1'b0;
        rst = 1'b1;
        for (int unsigned i = 0; i < 2; i++) begin
            tick();
            obs = {G1, GA, GB, wrap, C, B, A};
            n_cmp++;
            if (obs !== RESET_VEC) begin
                n_bad++;
                $display("FAIL reset_state cyc%0d: got %b expected %b", i, obs, RESET_VEC);
            end
        end
    endtask

    task automatic test_ascending();
        mask = 8'hFF; dir = 1'b0; run = 1'b1; dwell = 16'd3;
        do_reset();
        for (int unsigned k = 0; k < 8; k++) push_chan(k, 1'b0, 4);
        push_chan(0, 1'b1, 0);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            obs = {G1, GA, GB, wrap, C, B, A};
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL ascending: got %b expected %b", obs, e); end
        end
    endtask

    task automatic test_descending();
        mask = 8'b1010_0100; dir = 1'b1; run = 1'b1; dwell = 16'd3;
        do_reset();
        push_chan(7, 1'b0, 4);
        push_chan(5, 1'b0, 4);
        push_chan(2, 1'b0, 4);
        push_chan(7, 1'b1, 4);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            obs = {G1, GA, GB, wrap, C, B, A};
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL descending: got %b expected %b", obs, e); end
        end
    endtask

    task automatic test_hold_step();
        mask = 8'hFF; dir = 1'b0; run = 1'b1; dwell = 16'd3; step = 1'b0;
        do_reset();
        for (int unsigned k = 0; k < 3; k++) push_chan(k, 1'b0, 4);
        push_chan(3, 1'b0, 1);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            obs = {G1, GA, GB, wrap, C, B, A};
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL hold_lead_in: got %b expected %b", obs, e); end
        end
        run = 1'b0;
        for (int unsigned i = 0; i < 20; i++) exp_q.push_back({3'b100, 1'b0, 3'd3});
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            obs = {G1, GA, GB, wrap, C, B, A};
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL hold_ch3: got %b expected %b", obs, e); end
        end
        // step stays high into BLANK; only the first sampled edge may advance
        step = 1'b1;
        push_chan(4, 1'b0, 0);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            obs = {G1, GA, GB, wrap, C, B, A};
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL step_blank: got %b expected %b", obs, e); end
        end
        step = 1'b0;
        for (int unsigned i = 0; i < 3; i++) exp_q.push_back({3'b100, 1'b0, 3'd4});
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            obs = {G1, GA, GB, wrap, C, B, A};
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL step_show: got %b expected %b", obs, e); end
        end
    endtask

    task automatic test_forced_advance();
        mask = 8'hFF; dir = 1'b0; run = 1'b1; dwell = 16'd3; step = 1'b0;
        do_reset();
        for (int unsigned k = 0; k < 5; k++) push_chan(k, 1'b0, 4);
        push_chan(5, 1'b0, 1);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            obs = {G1, GA, GB, wrap, C, B, A};
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL forced_lead_in: got %b expected %b", obs, e); end
        end
        mask = 8'hDF;
        exp_q.push_back({3'b110, 1'b0, 3'd6});
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            obs = {G1, GA, GB, wrap, C, B, A};
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL forced_adv: got %b expected %b", obs, e); end
        end
        mask = 8'h00;
        for (int unsigned i = 0; i < 3; i++) exp_q.push_back({3'b011, 1'b0, 3'd6});
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            obs = {G1, GA, GB, wrap, C, B, A};
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL mask_off: got %b expected %b", obs, e); end
        end
    endtask

    task automatic test_single_channel();
        mask = 8'h10; dir = 1'b0; run = 1'b1; dwell = 16'd0; step = 1'b0;
        do_reset();
        push_chan(4, 1'b0, 1);
        for (int unsigned i = 0; i < 4; i++) push_chan(4, 1'b1, 1);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            obs = {G1, GA, GB, wrap, C, B, A};
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL single_chan: got %b expected %b", obs, e); end
        end
    endtask

    task automatic test_reset_mid_show();
        mask = 8'hFF; dir = 1'b0; run = 1'b1; dwell = 16'd3; step = 1'b0;
        do_reset();
        for (int unsigned k = 0; k < 6; k++) push_chan(k, 1'b0, 4);
        push_chan(6, 1'b0, 2);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            obs = {G1, GA, GB, wrap, C, B, A};
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL rst_lead_in: got %b expected %b", obs, e); end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs = {G1, GA, GB, wrap, C, B, A};
        n_cmp++;
        if (obs !== RESET_VEC) begin
            n_bad++;
            $display("FAIL rst_mid_show: got %b expected %b", obs, RESET_VEC);
        end
        push_chan(0, 1'b0, 4);
        push_chan(1, 1'b0, 1);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            obs = {G1, GA, GB, wrap, C, B, A};
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL rst_restart: got %b expected %b", obs, e); end
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; step = 1'b0; dir = 1'b0; dwell = 16'd3; mask = 8'hFF;
        test_reset();
        test_ascending();
        test_descending();
        test_hold_step();
        test_forced_advance();
        test_single_channel();
        test_reset_mid_show();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
